// File: rtl/u_receiver.sv
// UART 8N1 receiver: 2-flop rx synchroniser, mid-bit sampling FSM, valid/ready holding register.
// Latency: rx_valid rises 3 + BAUD_DIV/2 + 9*BAUD_DIV edges after the first edge that samples rx low.
// Backpressure: none on the line; a byte finishing while rx_valid & !rx_ready overwrites and sets sticky overrun.
module u_receiver #(
  parameter int BAUD_DIV = 5208,
  parameter int CNT_W    = 13
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  input  logic       rx_ready,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       overrun,
  output logic       frame_err,
  output logic       busy
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    STOP      = 3'd3,
    WAIT_IDLE = 3'd4
  } state_t;

  // Sample points: middle of the start bit, then one full bit period per sample.
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(BAUD_DIV / 2 - 1);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(BAUD_DIV - 1);

  logic             rx_meta;
  logic             rx_s;
  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       idx;
  logic [7:0]       shift;
  logic             cnt_clr;
  logic             bit_smp;
  logic             stop_ok;
  logic             stop_bad;

  // Two-flop synchroniser; idle-high line so flops reset to 1.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
    end
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state and sample strobes; the counter only runs inside a frame and is cleared on each sample.
  always_comb begin
    state_nxt = state;
    cnt_clr   = 1'b0;
    bit_smp   = 1'b0;
    stop_ok   = 1'b0;
    stop_bad  = 1'b0;
    case (state)
      IDLE: begin
        cnt_clr = 1'b1;
        if (!rx_s) state_nxt = START;
      end
      START: begin
        if (cnt == HALF_LAST) begin
          cnt_clr   = 1'b1;
          // A line back high at mid-start is a glitch: drop it silently.
          state_nxt = rx_s ? IDLE : DATA;
        end
      end
      DATA: begin
        if (cnt == BIT_LAST) begin
          cnt_clr = 1'b1;
          bit_smp = 1'b1;
          if (idx == 3'd7) state_nxt = STOP;
        end
      end
      STOP: begin
        if (cnt == BIT_LAST) begin
          cnt_clr = 1'b1;
          if (rx_s) begin
            stop_ok   = 1'b1;
            state_nxt = IDLE;
          end else begin
            stop_bad  = 1'b1;
            state_nxt = WAIT_IDLE;
          end
        end
      end
      WAIT_IDLE: begin
        // Line held low (break): wait for it to return high before hunting a new start edge.
        cnt_clr = 1'b1;
        if (rx_s) state_nxt = IDLE;
      end
      default: begin
        cnt_clr   = 1'b1;
        state_nxt = IDLE;
      end
    endcase
  end

  // Baud counter and bit index; the index restarts at 0 whenever we are outside the data phase.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
      idx <= 3'd0;
    end else begin
      if (cnt_clr) cnt <= '0;
      else         cnt <= cnt + 1'b1;
      if (state != DATA) idx <= 3'd0;
      else if (bit_smp)  idx <= idx + 3'd1;
    end
  end

  // Shift register, filled LSB first at each data sample.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)        shift <= 8'h00;
    else if (bit_smp) shift[idx] <= rx_s;
  end

  // Holding register with handshake, sticky overrun and one-cycle framing-error pulse.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_data   <= 8'h00;
      rx_valid  <= 1'b0;
      overrun   <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      frame_err <= stop_bad;
      if (stop_ok) begin
        // New byte always wins; a simultaneous handshake consumes the old one cleanly.
        rx_data  <= shift;
        rx_valid <= 1'b1;
        if (rx_valid && !rx_ready)     overrun <= 1'b1;
        else if (rx_valid && rx_ready) overrun <= 1'b0;
      end else if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
        overrun  <= 1'b0;
      end
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_u_receiver.sv
// Testbench for u_receiver at BAUD_DIV=16: directed scenarios plus randomized frames.
// Expected bytes/events are queued when a frame is sent; a monitor pops them as the DUT presents output.
// Holding-register occupancy and overrun are tracked by a small model in the stimulus.
module tb_u_receiver;

  localparam int BD = 16;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       rx = 1'b1;
  logic       rx_ready = 1'b0;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       overrun;
  logic       frame_err;
  logic       busy;

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic       is_ferr;
    logic [7:0] data;
    logic       ovr;
  } evt_t;

  evt_t exp_q[$];
  bit   ready_base = 1'b0;
  bit   m_full = 1'b0;
  bit   m_ovr = 1'b0;

  u_receiver #(.BAUD_DIV(BD), .CNT_W(5)) dut (
    .clk      (clk),
    .reset    (reset),
    .rx       (rx),
    .rx_ready (rx_ready),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .overrun  (overrun),
    .frame_err(frame_err),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: a byte is presented when rx_valid rises or its data changes while valid.
  initial begin : monitor
    logic       pv;
    logic [7:0] pd;
    evt_t       e;
    pv = 1'b0;
    pd = 8'h00;
    forever begin
      @(negedge clk);
      if (!reset) begin
        if (frame_err) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_frame_err: got pulse expected none");
          end else begin
            e = exp_q.pop_front();
            check("evt_is_frame_err", 32'(e.is_ferr), 32'h1);
          end
        end
        if (rx_valid && (!pv || rx_data != pd)) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_byte: got %0h expected none", rx_data);
          end else begin
            e = exp_q.pop_front();
            check("evt_is_byte", 32'(e.is_ferr), 32'h0);
            check("byte_data", 32'(rx_data), 32'(e.data));
            check("byte_overrun", 32'(overrun), 32'(e.ovr));
          end
        end
      end
      pv = rx_valid;
      pd = rx_data;
    end
  end

  // Watchdog.
  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Drive one frame bit-by-bit (one bit per BD cycles). rdy_cyc raises rx_ready on that cycle only;
  // abort_cyc asserts reset asynchronously on that cycle and ends the frame. Called at a negedge.
  task automatic send_frame(input logic [7:0] d, input bit stop, input int rdy_cyc,
                            input int abort_cyc, output int rise_c);
    logic [9:0] bits;
    bit         was_valid;
    bit         rdy_at_stop;
    evt_t       e;
    bits   = {stop, d, 1'b0};
    rise_c = -1;
    rdy_at_stop = ready_base || (rdy_cyc == 10 * BD - 6);
    if (abort_cyc < 0) begin
      if (stop) begin
        e.is_ferr = 1'b0;
        e.data    = d;
        e.ovr     = rdy_at_stop ? 1'b0 : (m_ovr | m_full);
        m_ovr     = e.ovr;
        m_full    = !ready_base;
      end else begin
        e.is_ferr = 1'b1;
        e.data    = 8'h00;
        e.ovr     = 1'b0;
      end
      exp_q.push_back(e);
    end
    for (int c = 0; c < 10 * BD; c++) begin
      was_valid = rx_valid;
      rx        = bits[c / BD];
      rx_ready  = (c == rdy_cyc) ? 1'b1 : ready_base;
      if (c == abort_cyc) begin
        #2 reset = 1'b1;
        #1;
        check("abort_rx_data", 32'(rx_data), 32'h0);
        check("abort_rx_valid", 32'(rx_valid), 32'h0);
        check("abort_overrun", 32'(overrun), 32'h0);
        check("abort_frame_err", 32'(frame_err), 32'h0);
        check("abort_busy", 32'(busy), 32'h0);
        rx       = 1'b1;
        rx_ready = 1'b0;
        repeat (3) @(negedge clk);
        reset  = 1'b0;
        m_full = 1'b0;
        m_ovr  = 1'b0;
        return;
      end
      @(negedge clk);
      if (rise_c < 0 && !was_valid && rx_valid) rise_c = c;
    end
    rx_ready = ready_base;
  endtask

  // Single-cycle rx_ready pulse.
  task automatic consume();
    rx_ready = 1'b1;
    @(negedge clk);
    rx_ready = ready_base;
    m_full   = 1'b0;
    m_ovr    = 1'b0;
  endtask

  // Wait (bounded) for every queued expectation to be observed.
  task automatic drain(input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 60) begin
      @(negedge clk);
      n++;
    end
    check(name, 32'(exp_q.size()), 32'h0);
  endtask

  initial begin : stim
    int         rc;
    int         bz;
    logic [7:0] d;
    bit         bad;
    reset    = 1'b1;
    rx       = 1'b1;
    rx_ready = 1'b0;
    idle(3);
    check("reset_rx_data", 32'(rx_data), 32'h0);
    check("reset_rx_valid", 32'(rx_valid), 32'h0);
    check("reset_overrun", 32'(overrun), 32'h0);
    check("reset_frame_err", 32'(frame_err), 32'h0);
    check("reset_busy", 32'(busy), 32'h0);
    reset = 1'b0;
    idle(5);

    // 1: single byte, latency
    send_frame(8'hA5, 1'b1, -1, -1, rc);
    check("t1_latency_edges", 32'(rc + 1), 32'(3 + BD / 2 + 9 * BD));
    drain("t1_drain");
    check("t1_rx_data_held", 32'(rx_data), 32'hA5);
    consume();
    check("t1_valid_cleared", 32'(rx_valid), 32'h0);
    idle(10);

    // 2: back-to-back without ready -> overrun, cleared by one handshake
    send_frame(8'h3C, 1'b1, -1, -1, rc);
    send_frame(8'hC3, 1'b1, -1, -1, rc);
    drain("t2_drain");
    check("t2_overrun", 32'(overrun), 32'h1);
    check("t2_rx_data", 32'(rx_data), 32'hC3);
    consume();
    check("t2_valid_cleared", 32'(rx_valid), 32'h0);
    check("t2_overrun_cleared", 32'(overrun), 32'h0);
    idle(10);

    // 3: ready on the exact second stop-sample cycle -> no overrun
    send_frame(8'h3C, 1'b1, -1, -1, rc);
    send_frame(8'hC3, 1'b1, 10 * BD - 6, -1, rc);
    drain("t3_drain");
    check("t3_overrun", 32'(overrun), 32'h0);
    check("t3_rx_valid", 32'(rx_valid), 32'h1);
    check("t3_rx_data", 32'(rx_data), 32'hC3);
    consume();
    idle(10);

    // 4: framing error, line held low, then a good frame
    send_frame(8'h55, 1'b0, -1, -1, rc);
    bz = 0;
    repeat (40) begin
      @(negedge clk);
      if (!busy) bz++;
    end
    check("t4_busy_low_cycles", 32'(bz), 32'h0);
    check("t4_rx_valid", 32'(rx_valid), 32'h0);
    drain("t4_drain_ferr");
    rx = 1'b1;
    idle(5);
    check("t4_idle_after_high", 32'(busy), 32'h0);
    send_frame(8'h81, 1'b1, -1, -1, rc);
    drain("t4_drain_81");
    consume();
    idle(10);

    // 5: 4-cycle glitch on idle line
    bz = 0;
    for (int c = 0; c < 30; c++) begin
      rx = (c < 4) ? 1'b0 : 1'b1;
      @(negedge clk);
      if (busy) bz++;
    end
    check("t5_busy_seen", 32'(bz >= 1), 32'h1);
    check("t5_busy_at_most_8", 32'(bz <= 8), 32'h1);
    check("t5_no_valid", 32'(rx_valid), 32'h0);
    idle(5);

    // 6: reset mid-frame with a byte pending, then a clean frame
    send_frame(8'h5A, 1'b1, -1, -1, rc);
    drain("t6_drain_5a");
    send_frame(8'hF0, 1'b1, -1, BD * 5 + BD / 2, rc);
    idle(5);
    send_frame(8'h0F, 1'b1, -1, -1, rc);
    drain("t6_drain_0f");
    consume();
    idle(10);

    // Randomized frames with rx_ready held high and occasional bad stop bits
    ready_base = 1'b1;
    rx_ready   = 1'b1;
    repeat (14) begin
      d   = 8'($urandom_range(0, 255));
      bad = ($urandom_range(0, 4) == 0);
      send_frame(d, !bad, -1, -1, rc);
      if (bad) begin
        idle($urandom_range(0, 30));
        rx = 1'b1;
      end
      idle($urandom_range(3, 20));
      drain("rand_drain");
    end
    ready_base = 1'b0;
    rx_ready   = 1'b0;
    idle(5);

    check("final_queue_empty", 32'(exp_q.size()), 32'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
